// File: rtl/cpu_bus_arbiter_pkg.sv
// Shared types for the CPU memory-bus arbiter: owner encoding, arbiter states
// and the request record held per port.
package cpu_bus_arbiter_pkg;

  localparam logic BUS_OWNER_DATA   = 1'b0;
  localparam logic BUS_OWNER_IFETCH = 1'b1;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [3:0]  byte_enable;
    logic [31:0] wdata;
  } bus_req_t;

  // Instruction fetches are always full-word reads.
  function automatic bus_req_t fetch_req(input logic [31:0] addr);
    return bus_req_t'{addr: addr, write: 1'b0, byte_enable: 4'b1111, wdata: 32'h0};
  endfunction

endpackage

// File: rtl/cpu_bus_arbiter_if.sv
// Signal bundle between the CPU ports, the arbiter and the memory interconnect.
// The arbiter uses the slave view; the surrounding core/bench uses the master view.
interface cpu_bus_arbiter_if;

  logic        dbus_request;
  logic [31:0] dbus_addr;
  logic        dbus_write;
  logic [3:0]  dbus_byte_enable;
  logic [31:0] dbus_wdata;
  logic        dbus_rvalid;
  logic [31:0] dbus_rdata;
  logic        dbus_busy;
  logic        dbus_error;

  logic        ibus_request;
  logic [31:0] ibus_addr;
  logic        ibus_rvalid;
  logic [31:0] ibus_rdata;
  logic        ibus_error;

  logic        mem_request;
  logic [31:0] mem_addr;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport slave (
    input  dbus_request, dbus_addr, dbus_write, dbus_byte_enable, dbus_wdata,
    output dbus_rvalid, dbus_rdata, dbus_busy, dbus_error,
    input  ibus_request, ibus_addr,
    output ibus_rvalid, ibus_rdata, ibus_error,
    output mem_request, mem_addr, mem_write, mem_byte_enable, mem_wdata,
    input  mem_rvalid, mem_rdata
  );

  modport master (
    output dbus_request, dbus_addr, dbus_write, dbus_byte_enable, dbus_wdata,
    input  dbus_rvalid, dbus_rdata, dbus_busy, dbus_error,
    output ibus_request, ibus_addr,
    input  ibus_rvalid, ibus_rdata, ibus_error,
    input  mem_request, mem_addr, mem_write, mem_byte_enable, mem_wdata,
    output mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/cpu_bus_req_latch.sv
// One-entry holding register for a single-cycle bus request pulse; stays full
// until the arbiter grants it.
module cpu_bus_req_latch
  import cpu_bus_arbiter_pkg::*;
(
  input  logic     clock,
  input  logic     reset,
  input  logic     capture,
  input  logic     clear,
  input  bus_req_t req_in,
  output logic     full,
  output bus_req_t req
);

  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset)        full <= 1'b0;
    else if (capture) full <= 1'b1;
    else if (clear)   full <= 1'b0;
  end

  // NOTE: the payload has no reset; it is only looked at while full is set.
  always_ff @(posedge clock) begin
    if (capture) req <= req_in;
  end

  // Upstream must not issue a second request before the first one is granted.
  a_no_overrun: assert property (@(posedge clock) disable iff (reset) !(capture && full && !clear));

endmodule

// File: rtl/cpu_bus_arbiter.sv
// Shares the external memory bus between the data and instruction-fetch ports,
// one transaction at a time, with fetch anti-starvation and a bus timeout.
module cpu_bus_arbiter
  import cpu_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_IF_WAIT    = 4
) (
  input logic              clock,
  input logic              reset,
  cpu_bus_arbiter_if.slave bus
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int WAIT_W  = $clog2(MAX_IF_WAIT + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WAIT_W-1:0]  WAIT_LIMIT = WAIT_W'(MAX_IF_WAIT);

  arb_state_t         state, state_next;
  logic               owner;
  logic               d_full, i_full;
  logic               grant_d, grant_i, complete, timeout;
  logic               data_done, if_done;
  logic [TIMER_W-1:0] timer;
  logic [WAIT_W-1:0]  if_wait_cnt;
  bus_req_t           d_req_in, i_req_in, d_req, i_req, win_req, cur_req, mem_req;

  assign d_req_in = bus_req_t'{addr: bus.dbus_addr, write: bus.dbus_write,
                               byte_enable: bus.dbus_byte_enable, wdata: bus.dbus_wdata};
  assign i_req_in = fetch_req(bus.ibus_addr);

  cpu_bus_req_latch u_data_latch (
    .clock(clock), .reset(reset), .capture(bus.dbus_request), .clear(grant_d),
    .req_in(d_req_in), .full(d_full), .req(d_req)
  );

  cpu_bus_req_latch u_fetch_latch (
    .clock(clock), .reset(reset), .capture(bus.ibus_request), .clear(grant_i),
    .req_in(i_req_in), .full(i_full), .req(i_req)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= ARB_IDLE;
    else       state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    grant_d    = 1'b0;
    grant_i    = 1'b0;
    complete   = 1'b0;
    timeout    = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (d_full || i_full) begin
          // Data wins unless fetch has already been passed over MAX_IF_WAIT times.
          if (i_full && (!d_full || if_wait_cnt == WAIT_LIMIT)) grant_i = 1'b1;
          else                                                   grant_d = 1'b1;
          state_next = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        timeout  = (timer == TIMER_LAST);
        complete = bus.mem_rvalid || timeout;
        if (complete) state_next = ARB_IDLE;
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  assign win_req = grant_i ? i_req : d_req;

  always_comb begin
    mem_req = '0;
    if (grant_d || grant_i)    mem_req = win_req;
    else if (state == ARB_BUSY) mem_req = cur_req;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      owner       <= BUS_OWNER_DATA;
      timer       <= '0;
      if_wait_cnt <= '0;
    end else begin
      if (grant_d || grant_i) begin
        owner <= grant_i ? BUS_OWNER_IFETCH : BUS_OWNER_DATA;
        timer <= '0;
      end else if (state == ARB_BUSY) begin
        timer <= timer + 1'b1;
      end
      if (grant_i || !i_full) if_wait_cnt <= '0;
      else if (grant_d)       if_wait_cnt <= if_wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (grant_d || grant_i) cur_req <= win_req;
  end

  assign bus.mem_request     = grant_d || grant_i;
  assign bus.mem_addr        = mem_req.addr;
  assign bus.mem_write       = mem_req.write;
  assign bus.mem_byte_enable = mem_req.byte_enable;
  assign bus.mem_wdata       = mem_req.wdata;

  // A real response beats a coincident timeout, so error only when mem_rvalid is absent.
  assign data_done       = complete && (owner == BUS_OWNER_DATA);
  assign if_done         = complete && (owner == BUS_OWNER_IFETCH);
  assign bus.dbus_rvalid = data_done;
  assign bus.dbus_error  = data_done && !bus.mem_rvalid;
  assign bus.dbus_rdata  = (data_done && bus.mem_rvalid) ? bus.mem_rdata : 32'h0;
  assign bus.ibus_rvalid = if_done;
  assign bus.ibus_error  = if_done && !bus.mem_rvalid;
  assign bus.ibus_rdata  = (if_done && bus.mem_rvalid) ? bus.mem_rdata : 32'h0;

  assign bus.dbus_busy = bus.dbus_request || d_full ||
                         (state == ARB_BUSY && owner == BUS_OWNER_DATA && !complete);

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Scoreboard bench for cpu_bus_arbiter: expected bus requests and responses are
// queued as stimulus is driven and retired as the arbiter produces them.
module tb_cpu_bus_arbiter;

  localparam int TIMEOUT = 255;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mreq_t;

  logic clock;
  logic reset;
  cpu_bus_arbiter_if bus ();

  cpu_bus_arbiter #(.TIMEOUT_CYCLES(TIMEOUT), .MAX_IF_WAIT(4)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  mreq_t       exp_mem_q[$];
  logic [32:0] exp_d_q[$];
  logic [32:0] exp_i_q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic        s_mreq, s_mwrite, s_dval, s_dbusy, s_derr, s_ival, s_ierr;
  logic [31:0] s_maddr, s_mwdata, s_drdata, s_irdata;
  logic [3:0]  s_mbe;
  logic [138:0] all_out;

  // One clock cycle: sample at the falling edge, retire scoreboard entries, then
  // step past the rising edge and drop the single-cycle pulses.
  task automatic tick();
    mreq_t got, e;
    logic [32:0] r;
    @(negedge clock);
    s_mreq = bus.mem_request;   s_maddr = bus.mem_addr;   s_mwrite = bus.mem_write;
    s_mbe  = bus.mem_byte_enable; s_mwdata = bus.mem_wdata;
    s_dval = bus.dbus_rvalid;   s_drdata = bus.dbus_rdata; s_dbusy = bus.dbus_busy;
    s_derr = bus.dbus_error;    s_ival = bus.ibus_rvalid;  s_irdata = bus.ibus_rdata;
    s_ierr = bus.ibus_error;
    all_out = {s_mreq, s_maddr, s_mwrite, s_mbe, s_mwdata, s_dval, s_drdata, s_dbusy,
               s_derr, s_ival, s_irdata, s_ierr};
    if (s_mreq) begin
      total++;
      got = mreq_t'{addr: s_maddr, write: s_mwrite, be: s_mbe, wdata: s_mwdata};
      if (exp_mem_q.size() == 0) begin
        bad++; $display("FAIL sb_mem_request: unexpected request %h at cycle %0d", got, cyc);
      end else begin
        e = exp_mem_q.pop_front();
        if (got !== e) begin bad++; $display("FAIL sb_mem_request: got %h required %h", got, e); end
      end
    end
    if (s_dval) begin
      total++;
      if (exp_d_q.size() == 0) begin
        bad++; $display("FAIL sb_dbus_resp: unexpected response err=%b rdata=%h at cycle %0d", s_derr, s_drdata, cyc);
      end else begin
        r = exp_d_q.pop_front();
        if ({s_derr, s_drdata} !== r) begin bad++; $display("FAIL sb_dbus_resp: got %h required %h", {s_derr, s_drdata}, r); end
      end
    end
    if (s_ival) begin
      total++;
      if (exp_i_q.size() == 0) begin
        bad++; $display("FAIL sb_ibus_resp: unexpected response err=%b rdata=%h at cycle %0d", s_ierr, s_irdata, cyc);
      end else begin
        r = exp_i_q.pop_front();
        if ({s_ierr, s_irdata} !== r) begin bad++; $display("FAIL sb_ibus_resp: got %h required %h", {s_ierr, s_irdata}, r); end
      end
    end
    total++;
    if ((!s_dval && (s_drdata !== 32'h0 || s_derr !== 1'b0)) ||
        (!s_ival && (s_irdata !== 32'h0 || s_ierr !== 1'b0)) || (s_dval && s_ival)) begin
      bad++; $display("FAIL resp_routing: cycle %0d dval=%b drdata=%h derr=%b ival=%b irdata=%h ierr=%b",
                      cyc, s_dval, s_drdata, s_derr, s_ival, s_irdata, s_ierr);
    end
    @(posedge clock);
    #1;
    bus.dbus_request = 1'b0;
    bus.ibus_request = 1'b0;
    bus.mem_rvalid   = 1'b0;
    bus.mem_rdata    = 32'h0;
    cyc++;
  endtask

  task automatic wait_mreq(input string name, output int n);
    n = 0;
    while (n < 20) begin
      tick();
      n++;
      if (s_mreq) return;
    end
    total++; bad++;
    $display("FAIL %s: no mem_request within %0d cycles", name, n);
  endtask

  task automatic drive_dbus(input logic [31:0] addr, input logic write,
                            input logic [3:0] be, input logic [31:0] wdata);
    bus.dbus_request = 1'b1; bus.dbus_addr = addr; bus.dbus_write = write;
    bus.dbus_byte_enable = be; bus.dbus_wdata = wdata;
  endtask

  task automatic drive_ibus(input logic [31:0] addr);
    bus.ibus_request = 1'b1; bus.ibus_addr = addr;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total++;
    if (all_out !== '0) begin bad++; $display("FAIL reset_outputs: got %h required 0", all_out); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    int n;
    drive_dbus(32'h100, 1'b0, 4'hF, 32'h0);
    exp_mem_q.push_back(mreq_t'{addr: 32'h100, write: 1'b0, be: 4'hF, wdata: 32'h0});
    exp_d_q.push_back({1'b0, 32'hDEADBEEF});
    tick();
    total++;
    if ({s_dbusy, s_mreq} !== 2'b10) begin bad++; $display("FAIL t1_cycle0: busy,mreq=%b required 10", {s_dbusy, s_mreq}); end
    tick();
    total++;
    if ({s_dbusy, s_mreq, s_maddr} !== {2'b11, 32'h100}) begin
      bad++; $display("FAIL t1_cycle1: busy,mreq,addr=%h required %h", {s_dbusy, s_mreq, s_maddr}, {2'b11, 32'h100});
    end
    tick();
    total++;
    if ({s_dbusy, s_mreq, s_maddr} !== {2'b10, 32'h100}) begin
      bad++; $display("FAIL t1_cycle2: busy,mreq,addr=%h required %h", {s_dbusy, s_mreq, s_maddr}, {2'b10, 32'h100});
    end
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
    tick();
    total++;
    if ({s_dval, s_dbusy} !== 2'b10) begin bad++; $display("FAIL t1_cycle3: rvalid,busy=%b required 10", {s_dval, s_dbusy}); end
    tick();
    n = exp_mem_q.size() + exp_d_q.size() + exp_i_q.size();
    total++;
    if (n != 0) begin bad++; $display("FAIL t1_drained: %0d entries left, required 0", n); end
  endtask

  task automatic test_simultaneous();
    int n;
    drive_dbus(32'h200, 1'b1, 4'b0011, 32'h1234);
    drive_ibus(32'h400);
    exp_mem_q.push_back(mreq_t'{addr: 32'h200, write: 1'b1, be: 4'b0011, wdata: 32'h1234});
    exp_mem_q.push_back(mreq_t'{addr: 32'h400, write: 1'b0, be: 4'hF, wdata: 32'h0});
    exp_d_q.push_back({1'b0, 32'h0});
    exp_i_q.push_back({1'b0, 32'h13});
    tick();
    wait_mreq("t2_data_grant", n);
    total++;
    if (s_maddr !== 32'h200) begin bad++; $display("FAIL t2_data_first: addr=%h required 00000200", s_maddr); end
    tick();
    bus.mem_rvalid = 1'b1;
    tick();
    wait_mreq("t2_fetch_grant", n);
    total++;
    if (n != 1 || s_maddr !== 32'h400) begin
      bad++; $display("FAIL t2_fetch_next: delay=%0d addr=%h required delay=1 addr=00000400", n, s_maddr);
    end
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h13;
    tick();
    total++;
    if (s_ival !== 1'b1) begin bad++; $display("FAIL t2_fetch_done: ibus_rvalid=%b required 1", s_ival); end
    n = exp_mem_q.size() + exp_d_q.size() + exp_i_q.size();
    total++;
    if (n != 0) begin bad++; $display("FAIL t2_drained: %0d entries left, required 0", n); end
  endtask

  task automatic test_if_starvation();
    int n;
    drive_ibus(32'h800);
    drive_dbus(32'h1000, 1'b0, 4'hF, 32'h0);
    for (int k = 0; k < 4; k++)
      exp_mem_q.push_back(mreq_t'{addr: 32'h1000 + 32'(4 * k), write: 1'b0, be: 4'hF, wdata: 32'h0});
    exp_mem_q.push_back(mreq_t'{addr: 32'h800, write: 1'b0, be: 4'hF, wdata: 32'h0});
    exp_mem_q.push_back(mreq_t'{addr: 32'h1010, write: 1'b0, be: 4'hF, wdata: 32'h0});
    for (int k = 0; k < 5; k++) exp_d_q.push_back({1'b0, 32'hA000 + 32'(k)});
    exp_i_q.push_back({1'b0, 32'h600D});
    tick();
    for (int k = 0; k < 4; k++) begin
      wait_mreq("t3_data_grant", n);
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hA000 + 32'(k);
      drive_dbus(32'h1000 + 32'(4 * (k + 1)), 1'b0, 4'hF, 32'h0);
      tick();
    end
    wait_mreq("t3_forced_fetch", n);
    total++;
    if (n != 1 || s_maddr !== 32'h800) begin
      bad++; $display("FAIL t3_forced_fetch: delay=%0d addr=%h required delay=1 addr=00000800", n, s_maddr);
    end
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h600D;
    tick();
    wait_mreq("t3_fifth_data", n);
    total++;
    if (s_maddr !== 32'h1010) begin bad++; $display("FAIL t3_fifth_data: addr=%h required 00001010", s_maddr); end
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hA004;
    tick();
    n = exp_mem_q.size() + exp_d_q.size() + exp_i_q.size();
    total++;
    if (n != 0) begin bad++; $display("FAIL t3_drained: %0d entries left, required 0", n); end
  endtask

  task automatic test_timeout();
    int n, m;
    drive_dbus(32'h300, 1'b1, 4'b0100, 32'h00AB0000);
    exp_mem_q.push_back(mreq_t'{addr: 32'h300, write: 1'b1, be: 4'b0100, wdata: 32'h00AB0000});
    exp_d_q.push_back({1'b1, 32'h0});
    tick();
    wait_mreq("t4_grant", n);
    m = 0;
    do begin tick(); m++; end while (!s_dval && m < 400);
    total++;
    if (m != TIMEOUT || s_derr !== 1'b1) begin
      bad++; $display("FAIL t4_timeout: cycles=%0d error=%b required cycles=%0d error=1", m, s_derr, TIMEOUT);
    end
    tick();
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h77;
    tick();
    total++;
    if ({s_dval, s_ival, s_mreq} !== 3'b000) begin
      bad++; $display("FAIL t4_stray_rvalid: dval,ival,mreq=%b required 000", {s_dval, s_ival, s_mreq});
    end
    n = exp_mem_q.size() + exp_d_q.size() + exp_i_q.size();
    total++;
    if (n != 0) begin bad++; $display("FAIL t4_drained: %0d entries left, required 0", n); end
  endtask

  task automatic test_reset_busy();
    int n;
    drive_dbus(32'h500, 1'b0, 4'hF, 32'h0);
    drive_ibus(32'h900);
    exp_mem_q.push_back(mreq_t'{addr: 32'h500, write: 1'b0, be: 4'hF, wdata: 32'h0});
    tick();
    wait_mreq("t5_grant", n);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h99;
    tick();
    total++;
    if (all_out !== '0) begin bad++; $display("FAIL t5_after_reset: outputs=%h required 0", all_out); end
    tick();
    tick();
    total++;
    if (s_mreq !== 1'b0) begin bad++; $display("FAIL t5_latch_cleared: mem_request=%b required 0", s_mreq); end
    n = exp_mem_q.size() + exp_d_q.size() + exp_i_q.size();
    total++;
    if (n != 0) begin bad++; $display("FAIL t5_drained: %0d entries left, required 0", n); end
  endtask

  task automatic test_rvalid_at_expiry();
    int n;
    drive_dbus(32'h600, 1'b0, 4'hF, 32'h0);
    exp_mem_q.push_back(mreq_t'{addr: 32'h600, write: 1'b0, be: 4'hF, wdata: 32'h0});
    exp_d_q.push_back({1'b0, 32'hCAFEF00D});
    tick();
    wait_mreq("t6_grant", n);
    for (int k = 0; k < TIMEOUT - 1; k++) tick();
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFEF00D;
    tick();
    total++;
    if ({s_dval, s_derr, s_drdata} !== {2'b10, 32'hCAFEF00D}) begin
      bad++; $display("FAIL t6_rvalid_wins: rvalid,error,rdata=%h required %h", {s_dval, s_derr, s_drdata}, {2'b10, 32'hCAFEF00D});
    end
    tick();
    n = exp_mem_q.size() + exp_d_q.size() + exp_i_q.size();
    total++;
    if (n != 0) begin bad++; $display("FAIL t6_drained: %0d entries left, required 0", n); end
  endtask

  initial begin
    reset = 1'b1;
    bus.dbus_request = 1'b0; bus.dbus_addr = 32'h0; bus.dbus_write = 1'b0;
    bus.dbus_byte_enable = 4'h0; bus.dbus_wdata = 32'h0;
    bus.ibus_request = 1'b0; bus.ibus_addr = 32'h0;
    bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
    test_reset();
    test_single_read();
    test_simultaneous();
    test_if_starvation();
    test_timeout();
    test_reset_busy();
    test_rvalid_at_expiry();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
